cache_miss_ctrl: RTL
====================

// Module: cache_miss_ctrl
// PURPOSE
//  Miss-handling sequencer for the 4-way set-associative cache.
//  Takes the miss/halt from the tag-compare stage, picks a victim (invalid way first, else tree-PLRU).
//  Writes back a dirty victim, fetches the missing 256-bit line over the DFP interface, and writes it into the arrays.
//  Then pulses replay so the pipeline re-issues the stalled access. Sits between stage 2 and the DFP port.
// PARAMETERS
//  WAYS     4    associativity (fixed 4; PLRU is 3-bit tree)
//  SET_W    4    set index width (16 sets; set = addr[8:5])
//  LINE_W   256  line width in bits (32-byte line; offset = addr[4:0])
//  TAG_W    23   tag width = 32-SET_W-5 (tag = addr[31:9])
// PORTS
//  clk           in   1       clock
//  rst           in   1       async reset, active-high
//  miss_valid    in   1       stage-2 miss (halt); sampled only in IDLE
//  miss_addr     in   32      address of missing access
//  valid_vec     in   4       valid bits of the indexed set
//  lru_read      in   3       PLRU bits of the indexed set
//  victim_dirty  in   1       dirty bit of way victim_way (external mux)
//  victim_tag    in   TAG_W   tag of way victim_way
//  victim_data   in   LINE_W  data of way victim_way
//  victim_way    out  2       chosen victim; drives external mux
//  dfp_addr      out  32      line-aligned DFP address
//  dfp_read      out  1       DFP read request
//  dfp_write     out  1       DFP write request
//  dfp_wdata     out  LINE_W  write-back data
//  dfp_rdata     in   LINE_W  fill data, valid with dfp_resp
//  dfp_resp      in   1       DFP completion, 1-cycle pulse
//  fill_we       out  1       array write strobe (data, tag, valid=1, dirty=0)
//  fill_set      out  SET_W   set written
//  fill_tag      out  TAG_W   tag written
//  fill_data     out  LINE_W  line written
//  lru_we        out  1       PLRU write strobe, same cycle as fill_we
//  lru_write     out  3       updated PLRU bits
//  stall         out  1       freeze pipeline
//  replay        out  1       1-cycle pulse: re-issue stalled access
// BEHAVIOUR
//  Reset: async, forces IDLE. All outputs 0, and all internal regs 0.
//  Reset mid-transaction drops dfp_read/dfp_write immediately and abandons the miss without any array write.
//  States: IDLE, ALLOC, WB, FILL, WRITE, REPLAY.
//  IDLE: miss_valid=1 -> latch miss_addr, latch victim_way, go to ALLOC.
//   Victim selection: if valid_vec != 4'hF, lowest-index invalid way.
//   Otherwise lru[2]=0 ? (lru[1] ? 1 : 0) : (lru[0] ? 3 : 2).
//  ALLOC (1 cycle): latch victim_tag/dirty/data and valid_vec[victim_way].
//   Go to WB if the victim is valid and dirty; otherwise go to FILL.
//  WB: dfp_write=1, dfp_addr={vtag,set,5'b0}, dfp_wdata=latched data.
//   All three are held stable until dfp_resp; on dfp_resp go to FILL.
//  FILL: dfp_read=1, dfp_addr={miss_addr[31:5],5'b0}, held until dfp_resp.
//   On dfp_resp latch dfp_rdata and go to WRITE.
//   dfp_resp in the first cycle of WB/FILL is accepted.
//   dfp_read and dfp_write are never asserted together.
//  WRITE (1 cycle): fill_we=1 and lru_we=1. fill_set=miss_addr[8:5], fill_tag=miss_addr[31:9], fill_data=latched line.
//   lru_write = lru_read with: bit2 = ~way[1]; if way[1]=0 then bit1 = ~way[0], else bit0 = ~way[0]; the third bit unchanged.
//  REPLAY (1 cycle): replay=1, stall=0, then go to IDLE.
//   miss_valid is ignored in REPLAY; the re-issued access is sampled next in IDLE.
//  stall = miss_valid in IDLE, and 1 in ALLOC/WB/FILL/WRITE.
//  dfp_resp is ignored outside WB/FILL. miss_valid is ignored outside IDLE.
//  Latency from miss sample to replay: clean = 3 + N_fill cycles; dirty = 3 + N_wb + N_fill.
//   N_x counts the request cycles up to and including dfp_resp.
//  All outputs other than stall are registered or decoded from state and latched regs only; there is no comb path from dfp_* inputs.
// TESTING
//  1. Clean miss to a set with valid_vec=4'b0111, miss_addr=32'h0000_1A40, fetch resp after 3 cycles
//     -> victim_way=3; dfp_read with addr 32'h0000_1A40; fill_set=2, fill_tag=23'h0D; lru_write[2]=0, lru_write[0]=0; replay 6 cycles after miss.
//  2. Dirty victim: valid_vec=4'hF, lru_read=3'b010, victim dirty, vtag=23'h7FFFFF
//     -> victim_way=1; dfp_write first to {vtag,set,5'b0}; dfp_read only after the write resp; no overlap.
//  3. Full set, clean, lru_read=3'b101 -> victim_way=3; lru_write=3'b000 after WRITE.
//  4. dfp_resp pulses in IDLE and ALLOC -> ignored; the FSM still waits for a resp in FILL.
//  5. rst asserted mid-FILL -> dfp_read=0 in the same cycle; no fill_we; IDLE, and a new miss is serviced normally afterwards.
//  6. miss_valid held high through REPLAY -> exactly one fill; replay pulses once; a second miss is taken only from IDLE.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// Bundle between the miss sequencer, the stage-2 tag/data arrays and the DFP port.
// The sequencer uses the master view; the surrounding cache (or a bench) uses the slave view.
interface cache_miss_ctrl_if;
  localparam int SET_W  = 4;
  localparam int LINE_W = 256;
  localparam int TAG_W  = 23;

  logic              miss_valid;
  logic [31:0]       miss_addr;
  logic [3:0]        valid_vec;
  logic [2:0]        lru_read;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_data;
  logic [1:0]        victim_way;
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic              fill_we;
  logic [SET_W-1:0]  fill_set;
  logic [TAG_W-1:0]  fill_tag;
  logic [LINE_W-1:0] fill_data;
  logic              lru_we;
  logic [2:0]        lru_write;
  logic              stall;
  logic              replay;

  modport master (
    input  miss_valid, miss_addr, valid_vec, lru_read,
    input  victim_dirty, victim_tag, victim_data,
    input  dfp_rdata, dfp_resp,
    output victim_way, dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output fill_we, fill_set, fill_tag, fill_data,
    output lru_we, lru_write, stall, replay
  );

  modport slave (
    output miss_valid, miss_addr, valid_vec, lru_read,
    output victim_dirty, victim_tag, victim_data,
    output dfp_rdata, dfp_resp,
    input  victim_way, dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  fill_we, fill_set, fill_tag, fill_data,
    input  lru_we, lru_write, stall, replay
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the 4-way cache: victim pick, optional write-back, line fetch,
// array fill with PLRU update, then a one-cycle replay pulse back to the pipeline.
module cache_miss_ctrl (
  input logic              clk,
  input logic              rst,
  cache_miss_ctrl_if.master bus
);
  localparam int LINE_W = 256;
  localparam int TAG_W  = 23;

  typedef enum logic [2:0] {IDLE, ALLOC, WB, FILL, WRITE, REPLAY} state_t;

  state_t            state;
  logic [26:0]       line_q;      // miss_addr[31:5]: tag plus set
  logic [2:0]        lru_q;
  logic [1:0]        way_q;
  logic [31:0]       dfp_addr_q;
  logic              dfp_read_q;
  logic              dfp_write_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] fill_data_q;
  logic              fill_we_q;
  logic              lru_we_q;
  logic [2:0]        lru_write_q;
  logic              replay_q;
  logic [1:0]        way_sel;
  logic [2:0]        lru_next;

  // Invalid ways are always preferred; the PLRU tree only decides among a full set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    way_sel = 2'd0;
    if (bus.valid_vec != 4'hF) begin
      for (int i = 3; i >= 0; i--)
        if (!bus.valid_vec[i]) way_sel = 2'(i);
    end else if (!bus.lru_read[2]) begin
      way_sel = bus.lru_read[1] ? 2'd1 : 2'd0;
    end else begin
      way_sel = bus.lru_read[0] ? 2'd3 : 2'd2;
    end
  end

  // Point the tree away from the way just filled; the other half's bit is untouched.
  always_comb begin
    lru_next    = lru_q;
    lru_next[2] = ~way_q[1];
    if (way_q[1]) lru_next[0] = ~way_q[0];
    else          lru_next[1] = ~way_q[0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      line_q      <= '0;
      lru_q       <= '0;
      way_q       <= '0;
      dfp_addr_q  <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      wdata_q     <= '0;
      fill_data_q <= '0;
      fill_we_q   <= 1'b0;
      lru_we_q    <= 1'b0;
      lru_write_q <= '0;
      replay_q    <= 1'b0;
    end else begin
      fill_we_q <= 1'b0;
      lru_we_q  <= 1'b0;
      replay_q  <= 1'b0;
      case (state)
        IDLE: if (bus.miss_valid) begin
          line_q <= bus.miss_addr[31:5];
          lru_q  <= bus.lru_read;
          way_q  <= way_sel;
          state  <= ALLOC;
        end
        ALLOC: if (bus.valid_vec[way_q] && bus.victim_dirty) begin
          dfp_write_q <= 1'b1;
          dfp_addr_q  <= {bus.victim_tag, line_q[3:0], 5'b0};
          wdata_q     <= bus.victim_data;
          state       <= WB;
        end else begin
          dfp_read_q <= 1'b1;
          dfp_addr_q <= {line_q, 5'b0};
          state      <= FILL;
        end
        WB: if (bus.dfp_resp) begin
          dfp_write_q <= 1'b0;
          dfp_read_q  <= 1'b1;
          dfp_addr_q  <= {line_q, 5'b0};
          state       <= FILL;
        end
        FILL: if (bus.dfp_resp) begin
          dfp_read_q  <= 1'b0;
          fill_data_q <= bus.dfp_rdata;
          fill_we_q   <= 1'b1;
          lru_we_q    <= 1'b1;
          lru_write_q <= lru_next;
          state       <= WRITE;
        end
        WRITE: begin
          replay_q <= 1'b1;
          state    <= REPLAY;
        end
        REPLAY:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.victim_way = way_q;
  assign bus.dfp_addr   = dfp_addr_q;
  assign bus.dfp_read   = dfp_read_q;
  assign bus.dfp_write  = dfp_write_q;
  assign bus.dfp_wdata  = wdata_q;
  assign bus.fill_we    = fill_we_q;
  assign bus.fill_set   = line_q[3:0];
  assign bus.fill_tag   = line_q[26:4];
  assign bus.fill_data  = fill_data_q;
  assign bus.lru_we     = lru_we_q;
  assign bus.lru_write  = lru_write_q;
  assign bus.replay     = replay_q;
  // Halt is forwarded combinationally in IDLE so the miss cycle itself is frozen.
  assign bus.stall      = (state == IDLE) ? bus.miss_valid : (state != REPLAY);

  logic unused_widths;
  assign unused_widths = &{1'b0, TAG_W[0]};
endmodule
